// File: rtl/game_round_ctrl_if.sv
// Signal bundle between the round controller and the rest of the game SoC.
// The controller side uses the master modport; the environment (CPU glue,
// video-domain hit logic, colorizer, Rojobot resets) uses the slave modport.
interface game_round_ctrl_if;
    // Player / CPU / video-domain inputs to the controller
    logic       start_btn;
    logic       map_sel;
    logic       tank_hit;
    logic       train_hit;
    logic       irq_ack;

    // Controller outputs
    logic [4:0] frame;
    logic       tank_reset;
    logic       train_reset;
    logic       fire_en;
    logic [2:0] tank_lives;
    logic [2:0] train_lives;
    logic [6:0] round_time;
    logic       game_over_irq;

    // Current FSM state, exposed for debug and checkers
    logic [2:0] dbg_state;

    // Handshake: game_over_irq is a sticky level raised when a round ends.
    // The CPU lowers it by pulsing irq_ack for at least one clk; if a new
    // raise and an ack land in the same clk, the raise wins and irq stays 1.
    // There is no ready/valid backpressure anywhere else on this bundle.

    modport master (
        input  start_btn,
        input  map_sel,
        input  tank_hit,
        input  train_hit,
        input  irq_ack,
        output frame,
        output tank_reset,
        output train_reset,
        output fire_en,
        output tank_lives,
        output train_lives,
        output round_time,
        output game_over_irq,
        output dbg_state
    );

    modport slave (
        output start_btn,
        output map_sel,
        output tank_hit,
        output train_hit,
        output irq_ack,
        input  frame,
        input  tank_reset,
        input  train_reset,
        input  fire_en,
        input  tank_lives,
        input  train_lives,
        input  round_time,
        input  game_over_irq,
        input  dbg_state
    );
endinterface

// File: rtl/game_round_ctrl.sv
// Round sequencer for the two-player Rojobot match (tank vs. train).
// Runs start screen -> arm -> play/respawn -> win/draw screen -> start,
// tracks lives and the round timer, and raises a sticky game-over flag.
// Hit and start inputs pass through 2-FF synchronisers before edge detect.
module game_round_ctrl #(
    parameter int LIVES          = 3,
    parameter int TICKS_PER_SEC  = 100000000,
    parameter int ROUND_SECS     = 99,
    parameter int WIN_HOLD_SECS  = 5,
    parameter int RESPAWN_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rstn,
    game_round_ctrl_if.master bus
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam longint HOLD_CYCLES = longint'(WIN_HOLD_SECS) * longint'(TICKS_PER_SEC);
    localparam longint CNT_MAX     = (HOLD_CYCLES > longint'(RESPAWN_CYCLES)) ?
                                     HOLD_CYCLES : longint'(RESPAWN_CYCLES);
    localparam int     CNT_W       = $clog2(CNT_MAX + 1);
    localparam int     PRE_W       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    localparam logic [CNT_W-1:0] RESPAWN_LOAD = CNT_W'(RESPAWN_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [2:0]       LIVES_INIT   = 3'(LIVES);
    localparam logic [6:0]       ROUND_INIT   = 7'(ROUND_SECS);

    localparam logic [4:0] FRAME_START = 5'b00001;
    localparam logic [4:0] FRAME_MAP1  = 5'b00010;
    localparam logic [4:0] FRAME_MAP2  = 5'b00100;
    localparam logic [4:0] FRAME_TANK  = 5'b01000;
    localparam logic [4:0] FRAME_TRAIN = 5'b10000;

    typedef enum logic [2:0] {
        S_START     = 3'd0,
        S_ARM       = 3'd1,
        S_PLAY      = 3'd2,
        S_RESPAWN   = 3'd3,
        S_WIN_TANK  = 3'd4,
        S_WIN_TRAIN = 3'd5,
        S_DRAW      = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Registers and their next values
    // ------------------------------------------------------------------
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [PRE_W-1:0] presc, presc_n;
    logic [2:0]       tank_lives, tank_lives_n;
    logic [2:0]       train_lives, train_lives_n;
    logic [6:0]       round_time, round_time_n;
    logic             map1, map1_n;
    logic             rsp_tank, rsp_tank_n;
    logic             rsp_train, rsp_train_n;
    logic             irq;
    logic [4:0]       frame_q;

    // Combinational helpers
    logic             enter_end;
    logic             tick;
    logic             timeout;
    logic [4:0]       frame_d;
    logic             tank_reset_d;
    logic             train_reset_d;
    logic             fire_en_d;

    // [0],[1]: synchroniser stages, [2]: previous synchronised value
    logic [2:0] start_sync;
    logic [2:0] tank_sync;
    logic [2:0] train_sync;

    logic start_edge;
    logic tank_edge;
    logic train_edge;

    // Saturating down-count shared by the arm, respawn and hold timers
    function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_ONE;
    endfunction

    // Synchronise the asynchronous-domain levels and keep one extra stage for edge detect
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start_sync <= '0;
            tank_sync  <= '0;
            train_sync <= '0;
        end else begin
            start_sync <= {start_sync[1:0], bus.start_btn};
            tank_sync  <= {tank_sync[1:0],  bus.tank_hit};
            train_sync <= {train_sync[1:0], bus.train_hit};
        end
    end

    assign start_edge = start_sync[1] & ~start_sync[2];
    assign tank_edge  = tank_sync[1]  & ~tank_sync[2];
    assign train_edge = train_sync[1] & ~train_sync[2];

    // Next-state, counters, lives and timer; every timed state is left on
    // the clk its counter reaches zero, so it lasts exactly its load value.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        presc_n       = presc;
        tank_lives_n  = tank_lives;
        train_lives_n = train_lives;
        round_time_n  = round_time;
        map1_n        = map1;
        rsp_tank_n    = rsp_tank;
        rsp_train_n   = rsp_train;
        enter_end     = 1'b0;
        tick          = 1'b0;
        timeout       = 1'b0;

        case (state)
            S_START: begin
                tank_lives_n  = LIVES_INIT;
                train_lives_n = LIVES_INIT;
                round_time_n  = ROUND_INIT;
                presc_n       = '0;
                if (start_edge) begin
                    map1_n  = bus.map_sel;
                    cnt_n   = RESPAWN_LOAD;
                    state_n = S_ARM;
                end
            end

            S_ARM: begin
                cnt_n = cnt_dec(cnt);
                if (cnt <= CNT_ONE) begin
                    state_n = S_PLAY;
                end
            end

            S_PLAY: begin
                if (presc == PRE_LAST) begin
                    presc_n = '0;
                    tick    = 1'b1;
                end else begin
                    presc_n = presc + PRE_W'(1);
                end
                if (tick && (round_time != 7'd0)) begin
                    round_time_n = round_time - 7'd1;
                end
                if (tank_edge && (tank_lives != 3'd0)) begin
                    tank_lives_n = tank_lives - 3'd1;
                end
                if (train_edge && (train_lives != 3'd0)) begin
                    train_lives_n = train_lives - 3'd1;
                end
                timeout = tick && (round_time_n == 7'd0);

                // Hits are applied first; any end condition then resolves
                // to the player with more lives left, equal lives is a draw.
                if ((tank_lives_n == 3'd0) || (train_lives_n == 3'd0) || timeout) begin
                    enter_end = 1'b1;
                    cnt_n     = HOLD_LOAD;
                    if (tank_lives_n > train_lives_n) begin
                        state_n = S_WIN_TANK;
                    end else if (tank_lives_n < train_lives_n) begin
                        state_n = S_WIN_TRAIN;
                    end else begin
                        state_n = S_DRAW;
                    end
                end else if (tank_edge || train_edge) begin
                    cnt_n       = RESPAWN_LOAD;
                    rsp_tank_n  = tank_edge;
                    rsp_train_n = train_edge;
                    state_n     = S_RESPAWN;
                end
            end

            S_RESPAWN: begin
                cnt_n = cnt_dec(cnt);
                if (cnt <= CNT_ONE) begin
                    state_n = S_PLAY;
                end
            end

            S_WIN_TANK, S_WIN_TRAIN, S_DRAW: begin
                cnt_n = cnt_dec(cnt);
                if (cnt <= CNT_ONE) begin
                    tank_lives_n  = LIVES_INIT;
                    train_lives_n = LIVES_INIT;
                    round_time_n  = ROUND_INIT;
                    presc_n       = '0;
                    state_n       = S_START;
                end
            end

            default: begin
                state_n = S_START;
            end
        endcase
    end

    // Moore outputs: bot resets, fire enable and the frame to be registered
    always_comb begin
        tank_reset_d  = 1'b1;
        train_reset_d = 1'b1;
        fire_en_d     = 1'b0;
        frame_d       = FRAME_START;

        case (state)
            S_ARM: begin
                frame_d = map1 ? FRAME_MAP1 : FRAME_MAP2;
            end
            S_PLAY: begin
                tank_reset_d  = 1'b0;
                train_reset_d = 1'b0;
                fire_en_d     = 1'b1;
                frame_d       = map1 ? FRAME_MAP1 : FRAME_MAP2;
            end
            S_RESPAWN: begin
                tank_reset_d  = rsp_tank;
                train_reset_d = rsp_train;
                frame_d       = map1 ? FRAME_MAP1 : FRAME_MAP2;
            end
            S_WIN_TANK: begin
                frame_d = FRAME_TANK;
            end
            S_WIN_TRAIN: begin
                frame_d = FRAME_TRAIN;
            end
            default: begin
                frame_d = FRAME_START;
            end
        endcase
    end

    // State, counters, scores and the frame register (frame lags state by one clk)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_START;
            cnt         <= '0;
            presc       <= '0;
            tank_lives  <= LIVES_INIT;
            train_lives <= LIVES_INIT;
            round_time  <= ROUND_INIT;
            map1        <= 1'b0;
            rsp_tank    <= 1'b0;
            rsp_train   <= 1'b0;
            frame_q     <= FRAME_START;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            presc       <= presc_n;
            tank_lives  <= tank_lives_n;
            train_lives <= train_lives_n;
            round_time  <= round_time_n;
            map1        <= map1_n;
            rsp_tank    <= rsp_tank_n;
            rsp_train   <= rsp_train_n;
            frame_q     <= frame_d;
        end
    end

    // Sticky game-over flag: a raise beats a simultaneous ack
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq <= 1'b0;
        end else if (enter_end) begin
            irq <= 1'b1;
        end else if (bus.irq_ack) begin
            irq <= 1'b0;
        end
    end

    assign bus.frame         = frame_q;
    assign bus.tank_reset    = tank_reset_d;
    assign bus.train_reset   = train_reset_d;
    assign bus.fire_en       = fire_en_d;
    assign bus.tank_lives    = tank_lives;
    assign bus.train_lives   = train_lives;
    assign bus.round_time    = round_time;
    assign bus.game_over_irq = irq;
    assign bus.dbg_state     = state;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: directed walk through a few matches followed
// by random play, checked each clk against a match-level reference model.
module tb_game_round_ctrl;

    localparam int LIVES    = 3;
    localparam int TICKS    = 10;
    localparam int ROUND    = 5;
    localparam int HOLD     = 2;
    localparam int RESP     = 4;
    localparam int HOLD_CYC = HOLD * TICKS;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    game_round_ctrl_if bus ();

    game_round_ctrl #(
        .LIVES          (LIVES),
        .TICKS_PER_SEC  (TICKS),
        .ROUND_SECS     (ROUND),
        .WIN_HOLD_SECS  (HOLD),
        .RESPAWN_CYCLES (RESP)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model of the match (lobby / frozen / fighting / result)
    // ------------------------------------------------------------------
    localparam int LOBBY  = 0;
    localparam int FROZEN = 1;
    localparam int FIGHT  = 2;
    localparam int SHOWN  = 3;

    int         m_mode;
    int         m_left;
    int         m_tl;
    int         m_rl;
    int         m_played;
    int         m_result;
    bit         m_map1;
    bit         m_mask_tank;
    bit         m_mask_train;
    bit         m_irq;
    logic [4:0] m_frame;
    bit   [3:0] h_start;
    bit   [3:0] h_tank;
    bit   [3:0] h_train;

    function automatic int time_left(input int played);
        int t;
        t = ROUND - played / TICKS;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic logic [4:0] frame_of(input int mode, input bit map1, input int result);
        if (mode == FROZEN || mode == FIGHT) return map1 ? 5'b00010 : 5'b00100;
        if (mode == SHOWN && result > 0) return 5'b01000;
        if (mode == SHOWN && result < 0) return 5'b10000;
        return 5'b00001;
    endfunction

    task automatic model_reset();
        m_mode = LOBBY; m_left = 0; m_tl = LIVES; m_rl = LIVES; m_played = 0;
        m_result = 0; m_map1 = 1'b0; m_mask_tank = 1'b1; m_mask_train = 1'b1;
        m_irq = 1'b0; m_frame = 5'b00001;
        h_start = '0; h_tank = '0; h_train = '0;
    endtask

    task automatic model_step();
        logic [4:0] f_next;
        bit st_e, tk_e, tr_e, set_irq;
        // history: [0] sampled now, [3] sampled three clks ago
        h_start = {h_start[2:0], bus.start_btn};
        h_tank  = {h_tank[2:0],  bus.tank_hit};
        h_train = {h_train[2:0], bus.train_hit};
        st_e = h_start[2] & ~h_start[3];
        tk_e = h_tank[2]  & ~h_tank[3];
        tr_e = h_train[2] & ~h_train[3];
        f_next  = frame_of(m_mode, m_map1, m_result);
        set_irq = 1'b0;
        case (m_mode)
            LOBBY: begin
                m_tl = LIVES; m_rl = LIVES; m_played = 0;
                if (st_e) begin
                    m_map1 = bus.map_sel; m_mode = FROZEN; m_left = RESP;
                    m_mask_tank = 1'b1; m_mask_train = 1'b1;
                end
            end
            FROZEN: begin
                m_left--;
                if (m_left == 0) m_mode = FIGHT;
            end
            FIGHT: begin
                m_played++;
                if (tk_e && m_tl > 0) m_tl--;
                if (tr_e && m_rl > 0) m_rl--;
                if (m_tl == 0 || m_rl == 0 || time_left(m_played) == 0) begin
                    m_mode = SHOWN; m_left = HOLD_CYC; set_irq = 1'b1;
                    m_result = (m_tl > m_rl) ? 1 : ((m_tl < m_rl) ? -1 : 0);
                end else if (tk_e || tr_e) begin
                    m_mode = FROZEN; m_left = RESP;
                    m_mask_tank = tk_e; m_mask_train = tr_e;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = LOBBY; m_tl = LIVES; m_rl = LIVES; m_played = 0;
                end
            end
        endcase
        if (set_irq) m_irq = 1'b1;
        else if (bus.irq_ack) m_irq = 1'b0;
        m_frame = f_next;
    endtask

    function automatic logic [21:0] expected();
        bit rst_tank, rst_train, fire;
        rst_tank  = (m_mode == FROZEN) ? m_mask_tank  : (m_mode != FIGHT);
        rst_train = (m_mode == FROZEN) ? m_mask_train : (m_mode != FIGHT);
        fire      = (m_mode == FIGHT);
        return {m_frame, rst_tank, rst_train, fire, 3'(m_tl), 3'(m_rl),
                7'(time_left(m_played)), m_irq};
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard: model advances on posedge, DUT compared on negedge
    // ------------------------------------------------------------------
    logic [21:0] exp_q[$];
    logic [21:0] sb_e;

    always @(posedge clk) begin
        if (!rstn) model_reset();
        else       model_step();
        exp_q.push_back(expected());
    end

    always @(negedge clk) begin
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'(0), 32'(1));
        end else begin
            sb_e = exp_q.pop_front();
            check("frame",        32'(bus.frame),          32'(sb_e[21:17]));
            check("tank_reset",   32'(bus.tank_reset),     32'(sb_e[16]));
            check("train_reset",  32'(bus.train_reset),    32'(sb_e[15]));
            check("fire_en",      32'(bus.fire_en),        32'(sb_e[14]));
            check("tank_lives",   32'(bus.tank_lives),     32'(sb_e[13:11]));
            check("train_lives",  32'(bus.train_lives),    32'(sb_e[10:8]));
            check("round_time",   32'(bus.round_time),     32'(sb_e[7:1]));
            check("irq",          32'(bus.game_over_irq),  32'(sb_e[0]));
            check("frame_onehot", 32'($onehot(bus.frame)), 32'(1));
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (inputs change 1 time unit after a negedge)
    // ------------------------------------------------------------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic press_start();
        bus.start_btn = 1'b1;
        cycles(2);
        bus.start_btn = 1'b0;
        cycles(1);
    endtask

    task automatic hit(input bit tk, input bit tr);
        bus.tank_hit  = tk;
        bus.train_hit = tr;
        cycles(2);
        bus.tank_hit  = 1'b0;
        bus.train_hit = 1'b0;
    endtask

    task automatic ack_pulse();
        bus.irq_ack = 1'b1;
        cycles(1);
        bus.irq_ack = 1'b0;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        #1;
        check("rst_frame",       32'(bus.frame),         32'(5'b00001));
        check("rst_tank_reset",  32'(bus.tank_reset),    32'(1));
        check("rst_train_reset", 32'(bus.train_reset),   32'(1));
        check("rst_fire_en",     32'(bus.fire_en),       32'(0));
        check("rst_tank_lives",  32'(bus.tank_lives),    32'(LIVES));
        check("rst_train_lives", 32'(bus.train_lives),   32'(LIVES));
        check("rst_round_time",  32'(bus.round_time),    32'(ROUND));
        check("rst_irq",         32'(bus.game_over_irq), 32'(0));
        cycles(3);
        rstn = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bus.start_btn = 1'b0;
        bus.map_sel   = 1'b1;
        bus.tank_hit  = 1'b0;
        bus.train_hit = 1'b0;
        bus.irq_ack   = 1'b0;
        cycles(1);
        apply_reset();

        // Start on map1, arm, then play
        press_start();
        cycles(5);
        check("play_frame_map1", 32'(bus.frame),      32'(5'b00010));
        check("play_fire_en",    32'(bus.fire_en),    32'(1));
        check("play_round_time", 32'(bus.round_time), 32'(ROUND));

        // One tank hit, then three train hits -> tank wins
        hit(1'b1, 1'b0);
        cycles(10);
        check("tank_hit_lives", 32'(bus.tank_lives), 32'(LIVES - 1));
        repeat (3) begin
            hit(1'b0, 1'b1);
            cycles(10);
        end
        check("win_tank_frame", 32'(bus.frame),         32'(5'b01000));
        check("win_tank_irq",   32'(bus.game_over_irq), 32'(1));
        cycles(HOLD_CYC);
        check("back_start_frame", 32'(bus.frame),         32'(5'b00001));
        check("back_start_lives", 32'(bus.train_lives),   32'(LIVES));
        check("irq_sticky",       32'(bus.game_over_irq), 32'(1));
        ack_pulse();
        check("irq_acked", 32'(bus.game_over_irq), 32'(0));

        // Simultaneous hits down to 1/1 then both zero -> draw
        press_start();
        cycles(6);
        repeat (2) begin
            hit(1'b1, 1'b1);
            cycles(8);
        end
        hit(1'b1, 1'b1);
        cycles(3);
        check("draw_frame",    32'(bus.frame),         32'(5'b00001));
        check("draw_fire_en",  32'(bus.fire_en),       32'(0));
        check("draw_lives",    32'({bus.tank_lives, bus.train_lives}), 32'(0));
        check("draw_irq",      32'(bus.game_over_irq), 32'(1));
        cycles(HOLD_CYC + 2);
        ack_pulse();

        // Lives 2/1 with a double hit -> tank wins
        press_start();
        cycles(6);
        hit(1'b0, 1'b1);
        cycles(8);
        hit(1'b1, 1'b1);
        cycles(8);
        hit(1'b1, 1'b1);
        cycles(3);
        check("double_hit_tank_win", 32'(bus.frame),       32'(5'b01000));
        check("double_hit_lives",    32'(bus.tank_lives),  32'(1));
        cycles(HOLD_CYC + 2);
        ack_pulse();

        // Round timer runs out with lives 3/2 -> tank wins
        press_start();
        cycles(6);
        hit(1'b0, 1'b1);
        cycles(60);
        check("timeout_frame", 32'(bus.frame),         32'(5'b01000));
        check("timeout_time",  32'(bus.round_time),    32'(0));
        check("timeout_irq",   32'(bus.game_over_irq), 32'(1));
        ack_pulse();
        check("timeout_ack", 32'(bus.game_over_irq), 32'(0));
        cycles(HOLD_CYC);

        // Ack held across the end-of-round raise: the raise wins for one clk
        bus.irq_ack = 1'b1;
        press_start();
        cycles(6);
        repeat (2) begin
            hit(1'b1, 1'b1);
            cycles(8);
        end
        hit(1'b1, 1'b1);
        cycles(1);
        check("set_beats_ack", 32'(bus.game_over_irq), 32'(1));
        cycles(1);
        check("ack_after_set", 32'(bus.game_over_irq), 32'(0));
        bus.irq_ack = 1'b0;
        cycles(HOLD_CYC);

        // Reset in the middle of a respawn, then map2 and an ignored start
        press_start();
        cycles(6);
        hit(1'b1, 1'b0);
        cycles(1);
        check("mid_respawn_tank_reset", 32'(bus.tank_reset), 32'(1));
        apply_reset();
        bus.map_sel = 1'b0;
        press_start();
        cycles(6);
        press_start();
        cycles(3);
        check("start_ignored_frame", 32'(bus.frame),   32'(5'b00100));
        check("start_ignored_fire",  32'(bus.fire_en), 32'(1));

        // Random play
        for (int i = 0; i < 2000; i++) begin
            bus.start_btn = ($urandom_range(0, 5) == 0);
            bus.map_sel   = 1'($urandom_range(0, 1));
            bus.tank_hit  = ($urandom_range(0, 7) == 0);
            bus.train_hit = ($urandom_range(0, 7) == 0);
            bus.irq_ack   = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 499) == 0) apply_reset();
            else cycles(1);
        end

        bus.start_btn = 1'b0;
        bus.tank_hit  = 1'b0;
        bus.train_hit = 1'b0;
        bus.irq_ack   = 1'b0;
        cycles(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Sequences a two-player Rojobot match (tank vs. train): start screen, map play, per-hit respawn, round timer and win screens.
- Drives the one-hot frame select consumed by the colorizer, the per-bot reset requests and the fire enable.
- Sits in the 100 MHz CPU/Wishbone domain beside the Rojobot controller.
- Hit inputs arrive from the 75 MHz video domain and are synchronised inside this block.

Parameters:
- LIVES, 3, lives per player at round start (1..7).
- TICKS_PER_SEC, 100000000, clk cycles per round-timer second.
- ROUND_SECS, 99, round length in seconds (1..127).
- WIN_HOLD_SECS, 5, seconds a win/draw screen is held before returning to start.
- RESPAWN_CYCLES, 16, length of a bot reset pulse in clk cycles (>=2).

Ports:
- clk  in  1  100 MHz clock
- rstn  in  1  asynchronous, active-low reset
- start_btn  in  1  debounced start button, level; rising edge used
- map_sel  in  1  1=map1, 0=map2; sampled when leaving START
- tank_hit  in  1  tank was hit, 75 MHz-domain level; 2-FF sync then rising edge
- train_hit  in  1  train was hit, same handling as tank_hit
- irq_ack  in  1  CPU acknowledge of game_over_irq, pulse
- frame  out  5  one-hot: [0] start, [1] map1, [2] map2, [3] tank win, [4] train win
- tank_reset  out  1  hold tank Rojobot in reset
- train_reset  out  1  hold train Rojobot in reset
- fire_en  out  1  bullets permitted
- tank_lives  out  3  tank lives remaining
- train_lives  out  3  train lives remaining
- round_time  out  7  seconds remaining
- game_over_irq  out  1  sticky end-of-round flag

Behaviour:
Reset (rstn low, asynchronous):
- state START; frame=5'b00001; tank_reset=train_reset=1; fire_en=0.
- lives=LIVES; round_time=ROUND_SECS; game_over_irq=0; prescaler=0; sync FFs cleared.

Input handling:
- All edges are detected on the synchronised signal. Hit edge latency into state logic: 3 clk.
- start_btn edges outside START are ignored.

States:
- START
  - frame=00001; both resets=1; fire_en=0.
  - Lives and round_time held at their reset values.
  - Start edge: latch map_sel, load respawn counter with RESPAWN_CYCLES, go to ARM.
- ARM
  - frame = map frame (bit1 if map1, else bit2); both resets=1; fire_en=0.
  - Counter decrements every clk; at 0, go to PLAY.
- PLAY
  - frame = map frame; resets=0; fire_en=1.
  - Prescaler counts 0..TICKS_PER_SEC-1. On wrap, round_time decrements (floor 0).
  - Single tank_hit edge: tank_lives-1.
    - Result 0: go to WIN_TRAIN.
    - Otherwise: go to RESPAWN, asserting tank_reset only.
  - train_hit is symmetric, going to WIN_TANK.
  - Both edges in the same cycle: both lives decrement.
    - Both 0: DRAW.
    - Exactly one 0: the other player wins.
    - Neither 0: RESPAWN with both resets asserted.
  - round_time reaching 0 (the same cycle it becomes 0):
    - Higher lives wins (tank higher -> WIN_TANK, train higher -> WIN_TRAIN).
    - Equal lives -> DRAW.
    - A hit in that same cycle is applied first, then the comparison is made.
- RESPAWN
  - frame = map frame; fire_en=0; prescaler and round_time frozen.
  - The hit bot's reset is held RESPAWN_CYCLES clk, then return to PLAY.
  - Hits during RESPAWN are ignored.
- WIN_TANK (frame=01000), WIN_TRAIN (frame=10000), DRAW (frame=00001)
  - Both resets=1; fire_en=0.
  - On entry: game_over_irq=1; hold counter loaded with WIN_HOLD_SECS*TICKS_PER_SEC.
  - At counter 0: go to START, reloading lives and round_time.

game_over_irq:
- Set on entry to any end state.
- Cleared by irq_ack. If set and ack coincide, set wins.
- Not cleared by the return to START.

Invariants:
- frame is exactly one-hot in every state and registered (changes 1 clk after the state transition).
- Lives never underflow below 0 and never exceed LIVES.
- Counter widths are sized by $clog2 of their maxima. Decrements saturate at 0.

Reset mid-operation:
- rstn low in any state returns to START with all reset values immediately.
- No pending hit or respawn survives reset.

Test Plan:
(TICKS_PER_SEC=10, ROUND_SECS=5, WIN_HOLD_SECS=2, RESPAWN_CYCLES=4, LIVES=3)
1. Reset, then start edge with map_sel=1 -> frame 00010 from ARM entry; resets=1 for 4 clk, then 0; fire_en=1 in PLAY; round_time=5.
2. In PLAY, one tank_hit pulse -> 3 clk later tank_lives=2; tank_reset=1 for 4 clk; train_reset stays 0; round_time frozen during respawn; back to PLAY.
3. Three train_hit pulses (separated beyond respawn) -> train_lives 3->2->1->0; frame=01000; game_over_irq=1; after 20 clk frame=00001 and lives reload to 3.
4. tank_hit and train_hit rising in the same cycle with both lives=1 -> DRAW: frame=00001, irq=1, both lives 0; with lives 2/1 -> WIN_TANK.
5. No hits for 50 clk of PLAY with lives 3/2 -> round_time 5->0; WIN_TANK; irq_ack pulse clears irq; irq_ack coinciding with a new set leaves irq=1.
6. rstn low mid-RESPAWN -> immediate START, frame=00001, both resets=1, lives=3, irq=0; start_btn edge in PLAY ignored.
